sme_arb: RTL and testbench

SME_ARB -- requirements
Module: sme_arb

---
 rtl/sme_pkg.sv | 18 +
 rtl/sme_rr_pick.sv | 22 ++
 rtl/sme_arb.sv | 141 ++++++++++++++
 tb/tb_sme_arb.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sme_pkg.sv
// Shared types and sizing for the two-requester string-match arbiter.
// The wait-timeout width and limit are used only when SME_ARB_TIMEOUT_EN is defined.
package sme_pkg;

    localparam int N_REQ       = 2;
    localparam int CHAR_W      = 8;
    localparam int IDX_W       = 5;
    localparam int TIMEOUT_CYC = 64;
    localparam int TMO_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } sme_state_e;

endpackage

// File: rtl/sme_rr_pick.sv
// Two-way round-robin pick: on a tie, the requester not served last wins.
// last = 1 means requester 1 was served most recently.
module sme_rr_pick
    import sme_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic             last,
    output logic [N_REQ-1:0] winner
);

    always_comb begin
        winner = '0;
        if (req[0] && req[1]) begin
            winner = last ? 2'b01 : 2'b10;
        end else if (req[0]) begin
            winner = 2'b01;
        end else if (req[1]) begin
            winner = 2'b10;
        end
    end

endmodule

// File: rtl/sme_arb.sv
// Arbitrates two requesters onto one shared string matcher and routes the result back.
// Define SME_ARB_TIMEOUT_EN to abandon a WAIT after TIMEOUT_CYC cycles with rsp_timeout=1.
//
// Handshake: a requester raises req and holds it until its rsp_valid bit pulses for one
// cycle; gnt (one-hot) is high from the first STREAM cycle through RESP; the matcher's
// eng_valid is honoured only in WAIT.
module sme_arb
    import sme_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [CHAR_W-1:0] chardata0,
    input  logic [CHAR_W-1:0] chardata1,
    input  logic              isstring0,
    input  logic              isstring1,
    input  logic              ispattern0,
    input  logic              ispattern1,
    output logic [N_REQ-1:0]  gnt,
    output logic [CHAR_W-1:0] eng_chardata,
    output logic              eng_isstring,
    output logic              eng_ispattern,
    input  logic              eng_valid,
    input  logic              eng_match,
    input  logic [IDX_W-1:0]  eng_match_index,
    output logic [N_REQ-1:0]  rsp_valid,
    output logic              rsp_match,
    output logic [IDX_W-1:0]  rsp_index,
    output logic              rsp_timeout,
    output logic [1:0]        dbg_state
);

    sme_state_e        state;
    logic [N_REQ-1:0]  win_q;
    logic              last_q;
    logic              pat_q;
    logic              match_q;
    logic [IDX_W-1:0]  idx_q;
    logic [N_REQ-1:0]  pick;
    logic [CHAR_W-1:0] sel_char;
    logic              sel_str;
    logic              sel_pat;
    logic              in_stream;
    logic              in_resp;

    sme_rr_pick u_pick (
        .req    ({req1, req0}),
        .last   (last_q),
        .winner (pick)
    );

    // Only the granted stream reaches the matcher; the other one is never looked at.
    always_comb begin
        sel_char = chardata0;
        sel_str  = isstring0;
        sel_pat  = ispattern0;
        if (win_q[1]) begin
            sel_char = chardata1;
            sel_str  = isstring1;
            sel_pat  = ispattern1;
        end
    end

    assign in_stream     = (state == ST_STREAM);
    assign in_resp       = (state == ST_RESP);
    assign eng_chardata  = in_stream ? sel_char : '0;
    assign eng_isstring  = in_stream && sel_str;
    assign eng_ispattern = in_stream && sel_pat;
    assign gnt           = (state == ST_IDLE) ? '0 : win_q;
    assign rsp_valid     = in_resp ? win_q : '0;
    assign rsp_match     = in_resp && match_q;
    assign rsp_index     = in_resp ? idx_q : '0;
    assign dbg_state     = state;

`ifdef SME_ARB_TIMEOUT_EN
    logic [TMO_W-1:0] wait_cnt;
    logic             tmo_q;
    assign rsp_timeout = in_resp && tmo_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            win_q   <= '0;
            last_q  <= 1'b1;
            pat_q   <= 1'b0;
            match_q <= 1'b0;
            idx_q   <= '0;
`ifdef SME_ARB_TIMEOUT_EN
            wait_cnt <= '0;
            tmo_q    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    pat_q <= 1'b0;
                    if (|pick) begin
                        win_q <= pick;
                        state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    // The pattern ends on the first high->low of the granted ispattern.
                    pat_q <= sel_pat;
                    if (pat_q && !sel_pat) begin
                        state <= ST_WAIT;
`ifdef SME_ARB_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (eng_valid) begin
                        match_q <= eng_match;
                        idx_q   <= eng_match_index;
                        state   <= ST_RESP;
`ifdef SME_ARB_TIMEOUT_EN
                        tmo_q   <= 1'b0;
                    end else if (wait_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                        match_q <= 1'b0;
                        idx_q   <= '0;
                        tmo_q   <= 1'b1;
                        state   <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                ST_RESP: begin
                    last_q <= win_q[1];
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sme_arb.sv
// Randomized bench for sme_arb: a transaction-level model predicts the grant order and responses.
// Define SME_ARB_TIMEOUT_EN for both bench and RTL to exercise the wait timeout.
module tb_sme_arb;
    import sme_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [7:0] chardata0, chardata1;
    logic       isstring0, isstring1, ispattern0, ispattern1;
    logic [1:0] gnt;
    logic [7:0] eng_chardata;
    logic       eng_isstring, eng_ispattern;
    logic       eng_valid, eng_match;
    logic [4:0] eng_match_index;
    logic [1:0] rsp_valid;
    logic       rsp_match;
    logic [4:0] rsp_index;
    logic       rsp_timeout;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int last_srv = 1;
    // {rsp_valid[1:0], rsp_match, rsp_index[4:0], rsp_timeout}
    logic [8:0] exp_q[$];

    sme_arb dut (
        .clk             (clk),
        .reset           (reset),
        .req0            (req0),
        .req1            (req1),
        .chardata0       (chardata0),
        .chardata1       (chardata1),
        .isstring0       (isstring0),
        .isstring1       (isstring1),
        .ispattern0      (ispattern0),
        .ispattern1      (ispattern1),
        .gnt             (gnt),
        .eng_chardata    (eng_chardata),
        .eng_isstring    (eng_isstring),
        .eng_ispattern   (eng_ispattern),
        .eng_valid       (eng_valid),
        .eng_match       (eng_match),
        .eng_match_index (eng_match_index),
        .rsp_valid       (rsp_valid),
        .rsp_match       (rsp_match),
        .rsp_index       (rsp_index),
        .rsp_timeout     (rsp_timeout),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] onehot(input int w);
        return (w == 0) ? 2'b01 : 2'b10;
    endfunction

    // Round-robin rule: a lone requester wins; on a tie the one not served last wins.
    function automatic int predict_winner(input logic [1:0] r);
        if (r == 2'b11) return (last_srv == 1) ? 0 : 1;
        return r[0] ? 0 : 1;
    endfunction

    // ---------------- drivers ----------------
    task automatic drive_src(input int n, input logic [7:0] c, input logic s, input logic p);
        if (n == 0) begin
            chardata0 = c; isstring0 = s; ispattern0 = p;
        end else begin
            chardata1 = c; isstring1 = s; ispattern1 = p;
        end
    endtask

    task automatic arbitrate(input logic [1:0] r, output int w);
        int t;
        t = 0;
        req0 = r[0];
        req1 = r[1];
        w = predict_winner(r);
        check("idle_gnt", 32'(gnt), 0);
        check("idle_eng", 32'({eng_chardata, eng_isstring, eng_ispattern}), 0);
        tick;
        while (gnt == 2'b00 && t < 4) begin
            tick;
            t++;
        end
        check("gnt", 32'(gnt), 32'(onehot(w)));
    endtask

    task automatic stream(input int w, input bit directed, input bit drop);
        string      txt;
        int         ls, lp;
        logic [7:0] c;
        logic       s, p;
        txt = "abcdbc";
        ls = directed ? 4 : $urandom_range(0, 4);
        lp = directed ? 2 : $urandom_range(1, 3);
        for (int i = 0; i <= ls + lp; i++) begin
            s = (i < ls);
            p = (i >= ls) && (i < ls + lp);
            c = (directed && i < 6) ? txt[i] : 8'($urandom);
            drive_src(w, c, s, p);
            drive_src(1 - w, 8'($urandom), 1'($urandom), 1'($urandom));
            eng_valid       = directed ? 1'b0 : 1'($urandom);
            eng_match       = 1'($urandom);
            eng_match_index = 5'($urandom);
            if (drop && i == 0) begin
                if (w == 0) req0 = 1'b0; else req1 = 1'b0;
            end
            #1;
            check("eng_chardata", 32'(eng_chardata), 32'(c));
            check("eng_isstring", 32'(eng_isstring), 32'(s));
            check("eng_ispattern", 32'(eng_ispattern), 32'(p));
            check("stream_rsp", 32'(rsp_valid), 0);
            tick;
        end
        eng_valid = 1'b0;
    endtask

    task automatic respond(input int w, input bit directed);
        int         nw;
        logic       m;
        logic [4:0] ix;
        nw = directed ? 1 : $urandom_range(0, 5);
        for (int i = 0; i < nw; i++) begin
            drive_src(w, 8'($urandom), 1'b0, 1'b0);
            drive_src(1 - w, 8'($urandom), 1'($urandom), 1'($urandom));
            #1;
            check("wait_eng", 32'({eng_chardata, eng_isstring, eng_ispattern}), 0);
            check("wait_rsp", 32'(rsp_valid), 0);
            check("wait_state", 32'(dbg_state), 32'(ST_WAIT));
            tick;
        end
        m  = directed ? 1'b1 : 1'($urandom);
        ix = directed ? 5'd1 : 5'($urandom);
        eng_valid       = 1'b1;
        eng_match       = m;
        eng_match_index = ix;
        exp_q.push_back({onehot(w), m, ix, 1'b0});
        tick;
        eng_valid       = 1'($urandom);
        eng_match       = 1'($urandom);
        eng_match_index = 5'($urandom);
    endtask

    task automatic finish_txn(input int w);
        logic [8:0] e;
        e = exp_q.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'(e[8:7]));
        check("rsp_match", 32'(rsp_match), 32'(e[6]));
        check("rsp_index", 32'(rsp_index), 32'(e[5:1]));
        check("rsp_timeout", 32'(rsp_timeout), 32'(e[0]));
        check("resp_gnt", 32'(gnt), 32'(onehot(w)));
        last_srv = w;
        if (w == 0) req0 = 1'($urandom); else req1 = 1'($urandom);
        tick;
        check("post_gnt", 32'(gnt), 0);
        check("post_rsp", 32'({rsp_valid, rsp_match, rsp_index, rsp_timeout}), 0);
        eng_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int         w;
        logic [1:0] r;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        drive_src(0, 8'h00, 1'b0, 1'b0);
        drive_src(1, 8'h00, 1'b0, 1'b0);
        eng_valid = 1'b0; eng_match = 1'b0; eng_match_index = '0;
        repeat (3) tick;
        check("rst_gnt", 32'(gnt), 0);
        check("rst_rsp", 32'({rsp_valid, rsp_match, rsp_index, rsp_timeout}), 0);
        check("rst_eng", 32'({eng_chardata, eng_isstring, eng_ispattern}), 0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        reset = 1'b0;
        tick;

        // Simultaneous first requests: requester 0 goes first.
        arbitrate(2'b11, w);
        check("first_tie", 32'(w), 0);
        stream(w, 1'b0, 1'b0);
        respond(w, 1'b0);
        finish_txn(w);

        for (int k = 0; k < 25; k++) begin
            r = {req1, req0} | 2'($urandom);
            if (r == 2'b00) r = 2'($urandom_range(1, 3));
            arbitrate(r, w);
            stream(w, 1'b0, $urandom_range(0, 3) == 0);
            respond(w, 1'b0);
            finish_txn(w);
        end

        // Reset while waiting on the matcher discards the transaction.
        arbitrate(2'b01, w);
        stream(w, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_gnt", 32'(gnt), 0);
        check("mid_rst_rsp", 32'(rsp_valid), 0);
        check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        req0 = 1'b0; req1 = 1'b0;
        last_srv = 1;
        @(negedge clk);
        reset = 1'b0;
        eng_valid = 1'b1; eng_match = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("late_valid_rsp", 32'(rsp_valid), 0);
            check("late_valid_gnt", 32'(gnt), 0);
        end
        eng_valid = 1'b0;

        // Requester 0 alone: string "abcd", pattern "bc", match at index 1.
        arbitrate(2'b01, w);
        stream(w, 1'b1, 1'b0);
        respond(w, 1'b1);
        finish_txn(w);

`ifdef SME_ARB_TIMEOUT_EN
        begin
            int n;
            n = 0;
            r = {req1, req0} | 2'b01;
            arbitrate(r, w);
            stream(w, 1'b0, 1'b0);
            exp_q.push_back({onehot(w), 1'b0, 5'd0, 1'b1});
            while (rsp_valid == 2'b00 && n < 100) begin
                tick;
                n++;
            end
            check("timeout_cycles", 32'(n), 64);
            finish_txn(w);
        end
`endif

        // Both held: strict alternation from the current pointer.
        for (int k = 0; k < 3; k++) begin
            arbitrate(2'b11, w);
            check("alt_winner", 32'(w), 32'(k == 0 ? (last_srv == 1 ? 0 : 1) : 1 - last_srv));
            stream(w, 1'b0, 1'b0);
            respond(w, 1'b0);
            finish_txn(w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
